// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// id_ex_operand_stage : ID/EX pipeline register with MEM/WB operand forwarding,
//                       load-use detection and final ALU operand selection.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
    parameter int          DW     = 32,
    parameter int          RW     = 5,
    parameter logic [5:0]  NOP_OP = 6'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [5:0]    id_alu_op,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_dst,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_src_imm,
    input  logic          id_src_shamt,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_dst,
    input  logic [DW-1:0] mem_fwd_data,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_fwd_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [5:0]    alu_op,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          load_use_hazard
);

    logic          valid_q,      valid_d;
    logic          reg_write_q,  reg_write_d;
    logic          mem_read_q,   mem_read_d;
    logic          mem_write_q,  mem_write_d;
    logic          mem_to_reg_q, mem_to_reg_d;
    logic [5:0]    alu_op_q,     alu_op_d;
    logic [RW-1:0] rs_q,         rs_d;
    logic [RW-1:0] rt_q,         rt_d;
    logic [RW-1:0] dst_q,        dst_d;
    logic [DW-1:0] rs_data_q,    rs_data_d;
    logic [DW-1:0] rt_data_q,    rt_data_d;
    logic [DW-1:0] imm_q,        imm_d;
    logic [4:0]    shamt_q,      shamt_d;
    logic          src_imm_q,    src_imm_d;
    logic          src_shamt_q,  src_shamt_d;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    assign load_use_hazard = valid_q & mem_read_q & (dst_q != '0) &
                             ((dst_q == id_rs) | (dst_q == id_rt));

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_op_d     = alu_op_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        dst_d        = dst_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        shamt_d      = shamt_q;
        src_imm_d    = src_imm_q;
        src_shamt_d  = src_shamt_q;
        // A flush or a load-use stall both inject a fully cleared bubble.
        if (flush || (!stall && load_use_hazard)) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            alu_op_d     = NOP_OP;
            rs_d         = '0;
            rt_d         = '0;
            dst_d        = '0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            shamt_d      = '0;
            src_imm_d    = 1'b0;
            src_shamt_d  = 1'b0;
        end else if (!stall) begin
            valid_d      = id_valid;
            reg_write_d  = id_reg_write  & id_valid;
            mem_read_d   = id_mem_read   & id_valid;
            mem_write_d  = id_mem_write  & id_valid;
            mem_to_reg_d = id_mem_to_reg & id_valid;
            alu_op_d     = id_alu_op;
            rs_d         = id_rs;
            rt_d         = id_rt;
            dst_d        = id_dst;
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            imm_d        = id_imm;
            shamt_d      = id_shamt;
            src_imm_d    = id_src_imm;
            src_shamt_d  = id_src_shamt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_op_q     <= NOP_OP;
            rs_q         <= '0;
            rt_q         <= '0;
            dst_q        <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            src_imm_q    <= 1'b0;
            src_shamt_q  <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_op_q     <= alu_op_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dst_q        <= dst_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            src_imm_q    <= src_imm_d;
            src_shamt_q  <= src_shamt_d;
        end
    end

    // Forwarding uses the registered indices, so a result landing during a stall is seen.
    always_comb begin
        fwd_rs = rs_data_q;
        if (mem_reg_write && (mem_dst != '0) && (mem_dst == rs_q)) begin
            fwd_rs = mem_fwd_data;
        end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == rs_q)) begin
            fwd_rs = wb_fwd_data;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (mem_reg_write && (mem_dst != '0) && (mem_dst == rt_q)) begin
            fwd_rt = mem_fwd_data;
        end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == rt_q)) begin
            fwd_rt = wb_fwd_data;
        end
    end

    assign alu_a         = src_shamt_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
    assign alu_b         = src_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_op        = alu_op_q;
    assign ex_dst        = dst_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
// tb_id_ex_operand_stage : directed and randomized checks of the ID/EX operand
//                          stage against an instruction-level reference model.
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SLL = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [5:0]  id_alu_op;
    logic [4:0]  id_rs, id_rt, id_dst, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_src_imm, id_src_shamt;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_dst, wb_dst;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [5:0]  alu_op;
    logic [4:0]  ex_dst;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_hazard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_src_imm(id_src_imm), .id_src_shamt(id_src_shamt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_fwd_data(mem_fwd_data),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_fwd_data(wb_fwd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
    );

    // Reference model: the instruction currently occupying EX.
    typedef struct packed {
        logic        v, rw, mr, mw, m2r;
        logic [5:0]  op;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh;
        logic        si, ssh;
    } ex_t;

    ex_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regval);
        if (idx == 0)                                 return regval;
        if (mem_reg_write && mem_dst == idx)          return mem_fwd_data;
        if (wb_reg_write && wb_dst == idx)            return wb_fwd_data;
        return regval;
    endfunction

    function automatic logic model_hazard();
        return m.v && m.mr && m.dst != 0 && (m.dst == id_rs || m.dst == id_rt);
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        if (!rst_n || flush)             return '0;
        if (stall)                       return m;
        if (model_hazard())              return '0;
        n.v   = id_valid;
        n.rw  = id_valid && id_reg_write;
        n.mr  = id_valid && id_mem_read;
        n.mw  = id_valid && id_mem_write;
        n.m2r = id_valid && id_mem_to_reg;
        n.op  = id_alu_op;
        n.rs  = id_rs;   n.rt  = id_rt;   n.dst = id_dst;
        n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm;
        n.sh  = id_shamt; n.si = id_src_imm; n.ssh = id_src_shamt;
        return n;
    endfunction

    task automatic check_model();
        logic [31:0] ea, eb, es;
        ea = m.ssh ? {27'b0, m.sh} : operand(m.rs, m.rsd);
        es = operand(m.rt, m.rtd);
        eb = m.si ? m.imm : es;
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("store", ex_store_data, es);
        chk("alu_op", {26'b0, alu_op}, {26'b0, m.op});
        chk("ex_dst", {27'b0, ex_dst}, {27'b0, m.dst});
        chk("ctrl", {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {27'b0, m.v, m.rw, m.mr, m.mw, m.m2r});
        chk("hazard", {31'b0, load_use_hazard}, {31'b0, model_hazard()});
    endtask

    // Check at the falling edge, advance one rising edge, return 1ns after it.
    task automatic cycle();
        ex_t n;
        @(negedge clk);
        check_model();
        n = model_next();
        @(posedge clk);
        #1;
        m = n;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0; id_alu_op = 0;
        id_rs = 0; id_rt = 0; id_dst = 0; id_shamt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_src_imm = 0; id_src_shamt = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        mem_reg_write = 0; mem_dst = 0; mem_fwd_data = 0;
        wb_reg_write = 0; wb_dst = 0; wb_fwd_data = 0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] dst, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_alu_op = op; id_rs = rs; id_rt = rt; id_dst = dst;
        id_rs_data = rsd; id_rt_data = rtd; id_reg_write = 1;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_src_imm = 0; id_src_shamt = 0; id_shamt = 0; id_imm = 0;
    endtask

    initial begin
        m = '0;
        clear_inputs();
        rst_n = 0;
        #12 rst_n = 1;
        @(posedge clk); #1;
        cycle();

        // ADD r3, r1, r2
        set_instr(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        cycle();
        id_valid = 0;
        #1;
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_op", {26'b0, alu_op}, {26'b0, OP_ADD});
        chk("add_dst", {27'b0, ex_dst}, 32'd3);

        // Double forward onto rs = r1, held in EX by a stall
        stall = 1;
        mem_reg_write = 1; mem_dst = 5'd1; mem_fwd_data = 32'h11;
        wb_reg_write  = 1; wb_dst  = 5'd1; wb_fwd_data  = 32'h22;
        #1 chk("fwd_mem_prio", alu_a, 32'h11);
        mem_reg_write = 0;
        #1 chk("fwd_wb", alu_a, 32'h22);
        mem_reg_write = 1; mem_dst = 0; wb_dst = 0;
        #1 chk("fwd_r0", alu_a, 32'd5);
        mem_reg_write = 0; wb_reg_write = 0;

        // Stall alone for 3 cycles; a new MEM match appears mid-stall
        cycle();
        mem_reg_write = 1; mem_dst = 5'd1; mem_fwd_data = 32'hCAFE;
        #1 chk("stall_fwd", alu_a, 32'hCAFE);
        cycle();
        mem_reg_write = 0;
        cycle();
        chk("stall_hold_op", {26'b0, alu_op}, {26'b0, OP_ADD});
        stall = 0;

        // Load-use: LW r4 in EX, then a consumer of r4 in ID
        set_instr(OP_LW, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        id_mem_read = 1; id_mem_to_reg = 1;
        cycle();
        set_instr(OP_ADD, 5'd4, 5'd9, 5'd10, 32'd1, 32'd2);
        #1 chk("lu_hazard", {31'b0, load_use_hazard}, 32'd1);
        cycle();
        chk("lu_bubble_v", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_op", {26'b0, alu_op}, 32'd0);
        chk("lu_clear", {31'b0, load_use_hazard}, 32'd0);
        cycle();
        chk("lu_capture_v", {31'b0, ex_valid}, 32'd1);
        chk("lu_capture_op", {26'b0, alu_op}, {26'b0, OP_ADD});

        // Stall and flush together
        stall = 1; flush = 1;
        cycle();
        chk("flush_v", {31'b0, ex_valid}, 32'd0);
        chk("flush_op", {26'b0, alu_op}, 32'd0);
        stall = 0; flush = 0;

        // SLL r5, r6, 4
        set_instr(OP_SLL, 5'd0, 5'd6, 5'd5, 32'd0, 32'h3);
        id_src_shamt = 1; id_shamt = 5'd4;
        cycle();
        id_valid = 0;
        #1;
        chk("sll_a", alu_a, 32'd4);
        chk("sll_b", alu_b, 32'd3);

        // ADDI with all-ones immediate; rt forwarded from MEM to the store path
        set_instr(OP_ADDI, 5'd2, 5'd7, 5'd7, 32'd1, 32'h55);
        id_src_imm = 1; id_imm = 32'hFFFF_FFFF;
        cycle();
        id_valid = 0;
        mem_reg_write = 1; mem_dst = 5'd7; mem_fwd_data = 32'hABCD;
        #1;
        chk("addi_b", alu_b, 32'hFFFF_FFFF);
        chk("addi_store", ex_store_data, 32'hABCD);
        cycle();

        // Randomized traffic with small register indices to provoke matches
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 5) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_alu_op     = 6'($urandom);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_dst        = 5'($urandom_range(0, 7));
            id_rs_data    = $urandom;
            id_rt_data    = $urandom;
            id_imm        = $urandom;
            id_shamt      = 5'($urandom);
            id_src_imm    = 1'($urandom);
            id_src_shamt  = ($urandom_range(0, 3) == 0);
            id_reg_write  = 1'($urandom);
            id_mem_read   = ($urandom_range(0, 2) == 0);
            id_mem_write  = 1'($urandom);
            id_mem_to_reg = 1'($urandom);
            mem_reg_write = 1'($urandom);
            mem_dst       = 5'($urandom_range(0, 7));
            mem_fwd_data  = $urandom;
            wb_reg_write  = 1'($urandom);
            wb_dst        = 5'($urandom_range(0, 7));
            wb_fwd_data   = $urandom;
            cycle();
        end

        // Asynchronous reset mid-stream, away from any clock edge
        #2 rst_n = 0;
        #1;
        m = '0;
        chk("rst_op", {26'b0, alu_op}, 32'd0);
        chk("rst_v", {31'b0, ex_valid}, 32'd0);
        chk("rst_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("rst_dst", {27'b0, ex_dst}, 32'd0);
        cycle();
        rst_n = 1;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
